// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared cycle types, constants and helpers for the SRAM responder
package sram_pkg;

   typedef enum logic [1:0] {
      CYC_IDLE,
      CYC_READ,
      CYC_WRITE
   } cyc_t;

   localparam int   CNT_W        = 16;
   localparam logic OOB_FILL_BIT = 1'b1;
   localparam int   READ_LAT_MIN = 1;
   localparam int   READ_LAT_MAX = 4;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// rtl/sram_rd_pipe.sv - DEPTH-stage read data/valid shift register, last stage is the output
module sram_rd_pipe #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_valid,
   input  logic [DATA_W-1:0] i_data,
   output logic              o_valid,
   output logic [DATA_W-1:0] o_data
);

   logic [DEPTH-1:0]  r_valid;
   logic [DATA_W-1:0] r_data [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= '0;
         for (int k = 0; k < DEPTH; k++) r_data[k] <= '0;
      end else begin
         r_valid[0] <= i_valid;
         r_data[0]  <= i_data;
         for (int k = 1; k < DEPTH; k++) begin
            r_valid[k] <= r_valid[k-1];
            r_data[k]  <= r_data[k-1];
         end
      end
   end

   assign o_valid = r_valid[DEPTH-1];
   assign o_data  = r_data[DEPTH-1];

endmodule

// File: rtl/sram_responder.sv
// rtl/sram_responder.sv - device-side 16-bit SRAM model with read latency, counters, error flags
// SRAM_BYTE_LANE_EN: honour UB_N/LB_N on writes and reads; otherwise always full width
module sram_responder
   import sram_pkg::*;
#(
   parameter int ADDR_W    = 18,
   parameter int DATA_W    = 16,
   parameter int MEM_DEPTH = 65536,
   parameter int READ_LAT  = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] SRAM_ADDR,
   inout  wire  [DATA_W-1:0] SRAM_DQ,
   input  logic              SRAM_WE_N,
   input  logic              SRAM_OE_N,
   input  logic              SRAM_CE_N,
   input  logic              SRAM_UB_N,
   input  logic              SRAM_LB_N,
   output logic [CNT_W-1:0]  wr_cnt,
   output logic [CNT_W-1:0]  rd_cnt,
   output logic              err_oob,
   output logic              err_coll
);

   localparam int HALF  = DATA_W / 2;
   localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam int LAT   = (READ_LAT < READ_LAT_MIN) ? READ_LAT_MIN :
                          (READ_LAT > READ_LAT_MAX) ? READ_LAT_MAX : READ_LAT;
   localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(MEM_DEPTH);

   logic [DATA_W-1:0] r_mem [MEM_DEPTH];
   logic [CNT_W-1:0]  r_wr_cnt, r_rd_cnt;
   logic              r_err_oob, r_err_coll;

   cyc_t              w_cyc;
   logic              w_oob, w_wr, w_rd, w_drive;
   logic [IDX_W-1:0]  w_idx;
   logic [1:0]        w_lane_en;
   logic [DATA_W-1:0] w_lane_mask, w_rd_data, w_out_data;
   logic              w_out_valid;

   always_comb begin
      w_cyc = CYC_IDLE;
      if (!SRAM_CE_N) begin
         if (!SRAM_WE_N)      w_cyc = CYC_WRITE;
         else if (!SRAM_OE_N) w_cyc = CYC_READ;
      end
   end

`ifdef SRAM_BYTE_LANE_EN
   assign w_lane_en = {~SRAM_UB_N, ~SRAM_LB_N};
`else
   logic w_unused_lanes;
   assign w_unused_lanes = SRAM_UB_N | SRAM_LB_N;
   assign w_lane_en      = 2'b11;
`endif

   assign w_lane_mask = {{HALF{w_lane_en[1]}}, {HALF{w_lane_en[0]}}};
   assign w_oob       = {1'b0, SRAM_ADDR} >= DEPTH_LIM;
   assign w_idx       = SRAM_ADDR[IDX_W-1:0];
   // A write with both lanes disabled is a no-op and is not counted.
   assign w_wr        = (w_cyc == CYC_WRITE) && (|w_lane_en);
   assign w_rd        = (w_cyc == CYC_READ);
   assign w_rd_data   = (w_oob ? {DATA_W{OOB_FILL_BIT}} : r_mem[w_idx]) & w_lane_mask;

   always_ff @(posedge clk) begin
      if (w_wr && !w_oob)
         r_mem[w_idx] <= (r_mem[w_idx] & ~w_lane_mask) | (SRAM_DQ & w_lane_mask);
   end

   sram_rd_pipe #(
      .DATA_W (DATA_W),
      .DEPTH  (LAT)
   ) u_rd_pipe (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_valid (w_rd),
      .i_data  (w_rd_data),
      .o_valid (w_out_valid),
      .o_data  (w_out_data)
   );

   // Never drive while WE_N is low, so controller writes cannot contend.
   assign w_drive = w_out_valid && !SRAM_CE_N && !SRAM_OE_N && SRAM_WE_N;
   assign SRAM_DQ = w_drive ? w_out_data : {DATA_W{1'bz}};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_cnt   <= '0;
         r_rd_cnt   <= '0;
         r_err_oob  <= 1'b0;
         r_err_coll <= 1'b0;
      end else begin
         if (w_wr)                                 r_wr_cnt   <= sat_inc(r_wr_cnt);
         if (w_drive)                              r_rd_cnt   <= sat_inc(r_rd_cnt);
         if ((w_wr || w_rd) && w_oob)              r_err_oob  <= 1'b1;
         if (w_out_valid && (!SRAM_WE_N || SRAM_OE_N)) r_err_coll <= 1'b1;
      end
   end

   assign wr_cnt   = r_wr_cnt;
   assign rd_cnt   = r_rd_cnt;
   assign err_oob  = r_err_oob;
   assign err_coll = r_err_coll;

endmodule

// File: tb/tb_sram_responder.sv
// tb/tb_sram_responder.sv - directed bench for sram_responder at READ_LAT 1, 2 and 3
module tb_sram_responder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [17:0] addr = '0;
   logic        we_n = 1'b1, oe_n = 1'b1, ce_n = 1'b1, ub_n = 1'b0, lb_n = 1'b0;
   logic [15:0] tb_dq = '0;
   logic        tb_en = 1'b0;
   wire  [15:0] dq1, dq2, dq3;
   logic [15:0] wc1, rc1, wc2, rc2, wc3, rc3;
   logic        oob1, coll1, oob2, coll2, oob3, coll3;
   int          n_cmp = 0;
   int          n_bad = 0;

   always #5 clk = ~clk;

   assign dq1 = tb_en ? tb_dq : 16'hzzzz;
   assign dq2 = tb_en ? tb_dq : 16'hzzzz;
   assign dq3 = tb_en ? tb_dq : 16'hzzzz;

   sram_responder #(.READ_LAT(1)) u_l1 (
      .clk(clk), .rst_n(rst_n), .SRAM_ADDR(addr), .SRAM_DQ(dq1),
      .SRAM_WE_N(we_n), .SRAM_OE_N(oe_n), .SRAM_CE_N(ce_n),
      .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n),
      .wr_cnt(wc1), .rd_cnt(rc1), .err_oob(oob1), .err_coll(coll1));

   sram_responder #(.READ_LAT(2)) u_l2 (
      .clk(clk), .rst_n(rst_n), .SRAM_ADDR(addr), .SRAM_DQ(dq2),
      .SRAM_WE_N(we_n), .SRAM_OE_N(oe_n), .SRAM_CE_N(ce_n),
      .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n),
      .wr_cnt(wc2), .rd_cnt(rc2), .err_oob(oob2), .err_coll(coll2));

   sram_responder #(.READ_LAT(3)) u_l3 (
      .clk(clk), .rst_n(rst_n), .SRAM_ADDR(addr), .SRAM_DQ(dq3),
      .SRAM_WE_N(we_n), .SRAM_OE_N(oe_n), .SRAM_CE_N(ce_n),
      .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n),
      .wr_cnt(wc3), .rd_cnt(rc3), .err_oob(oob3), .err_coll(coll3));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [17:0] a, input logic [15:0] d,
                     input logic ub = 1'b0, input logic lb = 1'b0);
      addr = a; tb_dq = d; tb_en = 1'b1;
      ce_n = 1'b0; we_n = 1'b0; oe_n = 1'b1; ub_n = ub; lb_n = lb;
      tick();
   endtask

   task automatic rd(input logic [17:0] a, input logic ub = 1'b0, input logic lb = 1'b0);
      addr = a; tb_en = 1'b0;
      ce_n = 1'b0; we_n = 1'b1; oe_n = 1'b0; ub_n = ub; lb_n = lb;
      tick();
   endtask

   // Chip deselected with OE low: pending reads drain without collision or count.
   task automatic drain(input int n);
      ce_n = 1'b1; we_n = 1'b1; oe_n = 1'b0; tb_en = 1'b0; ub_n = 1'b0; lb_n = 1'b0;
      repeat (n) tick();
   endtask

   task automatic do_reset();
      drain(1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      drain(1);
   endtask

   initial begin
      repeat (2) tick();
      chk("reset_wr_cnt", wc1, 0);
      chk("reset_rd_cnt", rc1, 0);
      chk("reset_err_oob", oob1, 0);
      chk("reset_err_coll", coll3, 0);
      rst_n = 1'b1;
      drain(1);

      // Write then read at READ_LAT=1
      wr(18'h00010, 16'hBEEF);
      rd(18'h00010);
      chk("lat1_rd_data", dq1, 16'hBEEF);
      rd(18'h00010);
      drain(4);
      chk("lat1_rd_cnt", rc1, 1);
      chk("lat1_wr_cnt", wc1, 1);

      // 32-bit controller sequence, back-to-back reads
      wr(18'h00200, 16'h5678);
      wr(18'h00201, 16'h1234);
      rd(18'h00200);
      chk("b2b_lo", dq1, 16'h5678);
      rd(18'h00201);
      chk("b2b_hi", dq1, 16'h1234);
      drain(4);
      chk("b2b_rd_cnt", rc1, 2);
      chk("b2b_wr_cnt", wc1, 3);
      chk("b2b_no_coll", coll1, 0);

      // READ_LAT=3 collision with a write to the in-flight address
      do_reset();
      chk("lat3_coll_clear", coll3, 0);
      wr(18'h00030, 16'h1111);
      rd(18'h00030);
      wr(18'h00030, 16'h2222);
      wr(18'h00030, 16'h2222);
      wr(18'h00030, 16'h2222);
      ce_n = 1'b1; we_n = 1'b1; oe_n = 1'b1; tb_en = 1'b0;
      tick();
      chk("lat3_err_coll", coll3, 1);
      chk("lat3_rd_cnt", rc3, 0);
      chk("lat3_wr_cnt", wc3, 4);
      rd(18'h00030);
      rd(18'h00030);
      rd(18'h00030);
      chk("lat3_new_data", dq3, 16'h2222);
      drain(4);

      // Out-of-range address
      do_reset();
      wr(18'h0FFFF, 16'hC0DE);
      chk("oob_clear", oob1, 0);
      rd(18'h3FFFF);
      chk("oob_rd_fill", dq1, 16'hFFFF);
      chk("oob_rd_flag", oob1, 1);
      rd(18'h0FFFF);
      chk("oob_alias_before", dq1, 16'hC0DE);
      drain(4);
      wr(18'h3FFFF, 16'h1234);
      rd(18'h0FFFF);
      chk("oob_no_array_change", dq1, 16'hC0DE);
      rd(18'h0FFFF);
      drain(4);

      // Byte lanes
      wr(18'h00040, 16'hAAAA);
      wr(18'h00040, 16'h5555, 1'b1, 1'b0);
      rd(18'h00040);
`ifdef SRAM_BYTE_LANE_EN
      chk("lane_merge", dq1, 16'hAA55);
`else
      chk("lane_ignored", dq1, 16'h5555);
`endif
      rd(18'h00040, 1'b1, 1'b0);
`ifdef SRAM_BYTE_LANE_EN
      chk("lane_rd_mask", dq1, 16'h0055);
`else
      chk("lane_rd_full", dq1, 16'h5555);
`endif
      drain(4);

      // Reset in the middle of a READ_LAT=2 read burst
      wr(18'h00050, 16'h7E57);
      rd(18'h00050);
      rd(18'h00050);
      rd(18'h00050);
      chk("lat2_rd_data", dq2, 16'h7E57);
      chk("lat2_rd_cnt_pre", rc2, 1);
      rst_n = 1'b0;
      tb_dq = 16'h0000;
      tb_en = 1'b1;
      #1;
      chk("rst_dq_released", dq2, 16'h0000);
      chk("rst_rd_cnt", rc2, 0);
      chk("rst_wr_cnt", wc2, 0);
      chk("rst_err_oob", oob2, 0);
      #1;
      rst_n = 1'b1;
      drain(4);
      rd(18'h00050);
      rd(18'h00050);
      chk("rst_data_kept", dq2, 16'h7E57);
      drain(4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/sram_responder.md
Name: sram_responder

Overview:
- Cycle-based device-side model of the 16-bit external SRAM, i.e. the responder on the SRAM pin interface driven by the memory-stage SRAM controller.
- Accepts address/strobe pins, stores writes into an internal array, returns read data on the shared tri-state DQ bus after a programmable latency.
- Provides access counters and sticky error flags so benches and FPGA self-tests can check controller protocol compliance.

Parameters:
- ADDR_W, 18, SRAM_ADDR width.
- DATA_W, 16, SRAM_DQ width; must be even (two byte lanes).
- MEM_DEPTH, 65536, implemented words; must be ≤ 2**ADDR_W.
- READ_LAT, 1, cycles from read address sample to DQ drive; legal range 1..4.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- SRAM_ADDR  in  ADDR_W  word address.
- SRAM_DQ  inout  DATA_W  bidirectional data.
- SRAM_WE_N  in  1  write enable, active-low.
- SRAM_OE_N  in  1  output enable, active-low.
- SRAM_CE_N  in  1  chip enable, active-low.
- SRAM_UB_N  in  1  upper byte enable, active-low.
- SRAM_LB_N  in  1  lower byte enable, active-low.
- wr_cnt  out  16  accepted writes, saturating.
- rd_cnt  out  16  delivered reads, saturating.
- err_oob  out  1  sticky: access with SRAM_ADDR ≥ MEM_DEPTH.
- err_coll  out  1  sticky: read result dropped by a write collision.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - Read pipeline valid bits cleared.
  - wr_cnt=0, rd_cnt=0, err_oob=0, err_coll=0.
  - DQ released to high-Z.
  - Array contents are NOT cleared.
  - A reset mid-access drops any in-flight read with no flag.
- Cycle classification at each posedge clk (CE_N=0 required, otherwise IDLE):
  - WRITE: WE_N=0.
  - READ: WE_N=1 and OE_N=0.
  - IDLE: anything else.
- WRITE:
  - mem[ADDR] <= DQ, honouring byte lanes (see Optional Feature).
  - wr_cnt increments.
  - Out-of-range address: no array update, err_oob set.
- READ:
  - Launches pipeline stage 0 with data = mem[ADDR] and valid=1.
  - Out-of-range address returns all-ones and sets err_oob.
  - Data is captured at launch: a write to the same address while the read is in flight does not alter the returned value.
  - A write at cycle N followed by a read of the same address at N+1 returns the new data.
- Pipeline:
  - READ_LAT stages, shifting every cycle.
  - Stage READ_LAT-1 is the output stage.
  - With READ_LAT=1, an address sampled at edge N is driven on DQ throughout cycle N+1. This timing matches the controller's address-low/address-high back-to-back read sequence.
- DQ drive:
  - Driven = output valid AND CE_N=0 AND OE_N=0 AND WE_N=1.
  - Otherwise high-Z.
  - The device never drives while WE_N=0, so there is no bus contention with controller writes.
- rd_cnt increments on each cycle the output stage is valid and driven.
- Collision:
  - Output stage valid while WE_N=0 or OE_N=1 means the data is dropped and err_coll is set.
  - The pipeline keeps shifting; there is no stall.
- Back-to-back reads: one launch per cycle, full throughput.
- Counters saturate at 16'hFFFF and do not wrap.
- Sticky flags clear only on reset.

Optional Feature:
- Macro: SRAM_BYTE_LANE_EN.
- Defined:
  - LB_N=0 writes bits [DATA_W/2-1:0]; UB_N=0 writes the upper half.
  - Both high: cycle is a no-op write and is not counted.
  - On reads, a disabled lane drives zeros.
- Undefined:
  - UB_N/LB_N are ignored (controller ties them low).
  - Every write and read is full-width.

Decomposition:
- Shared package sram_pkg: cycle-type enum (IDLE/READ/WRITE), counter width constant 16, out-of-range fill constant (all-ones), READ_LAT legal-range constants.
- One sub-module: sram_rd_pipe, the parameterised READ_LAT-deep data+valid shift register with async active-low reset.
- Array, decode, counters and flags stay in the top.

Test Plan:
- Write 16'hBEEF @ addr 18'h00010, then READ_LAT=1 read of the same address -> DQ=16'hBEEF in the cycle after the address, rd_cnt=1, wr_cnt=1.
- Controller-style 32-bit sequence: writes 16'h5678 @ 2k and 16'h1234 @ 2k+1, then back-to-back reads -> DQ 16'h5678 then 16'h1234 on consecutive cycles.
- READ_LAT=3: read launched, then a write to the same address 1 cycle later with OE_N=1 -> err_coll=1, array holds the new value, a later read returns the new value.
- Address 18'h3FFFF with MEM_DEPTH=65536 -> err_oob=1, read returns 16'hFFFF, no array change.
- SRAM_BYTE_LANE_EN defined: write 16'hAAAA, then write 16'h5555 with UB_N=1, LB_N=0 -> read returns 16'hAA55.
- Reset asserted mid-read (READ_LAT=2) -> DQ high-Z immediately, counters 0, previously written data still readable after reset.
